// File: rtl/shift_seq_pkg.sv
// Shared constants and types for the multi-pass shift sequencer.
//   DATA_W           : operand / result width (matches barrel_shifter)
//   SHIFT_W          : barrel_shifter shift-amount width
//   STEP_MAX_DEFAULT : default largest per-pass shift
//   DIR_LEFT/RIGHT   : direction encoding shared with barrel_shifter
//   state_t          : sequencer FSM states
package shift_seq_pkg;

    localparam int unsigned DATA_W           = 8;
    localparam int unsigned SHIFT_W          = 3;
    localparam int unsigned STEP_MAX_DEFAULT = 7;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/shift_sequencer_if.sv
// Command / result handshake bundle for shift_sequencer.
//   in_*  : command channel (valid/ready), operand, direction, total amount
//   out_* : result channel (valid/ready), shifted data
//   master modport: producer/consumer side; slave modport: sequencer side
interface shift_sequencer_if
    import shift_seq_pkg::*;
#(
    parameter int unsigned AMT_W = 5
) ();

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_dir;
    logic [AMT_W-1:0]  in_amt;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;

    modport master (
        output in_valid, in_data, in_dir, in_amt, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, in_dir, in_amt, out_ready,
        output in_ready, out_valid, out_data
    );

endinterface

// File: rtl/barrel_shifter.sv
// Combinational logical barrel shifter, zero fill, no rotation.
//   IN    : operand
//   OUT   : shifted result
//   dir   : 0 = left, 1 = right
//   shift : shift amount 0..7
module barrel_shifter
    import shift_seq_pkg::*;
(
    input  logic [DATA_W-1:0]  IN,
    output logic [DATA_W-1:0]  OUT,
    input  logic               dir,
    input  logic [SHIFT_W-1:0] shift
);

    always_comb begin
        OUT = (dir == DIR_RIGHT) ? (IN >> shift) : (IN << shift);
    end

endmodule

// File: rtl/shift_sequencer.sv
// Splits long shift commands into passes of at most STEP_MAX positions and
// recirculates the barrel_shifter result through a local accumulator.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : command/result handshake (slave side)
//   busy       : high while a command is in RUN or DONE
module shift_sequencer
    import shift_seq_pkg::*;
#(
    parameter int unsigned AMT_W    = 5,
    parameter int unsigned STEP_MAX = STEP_MAX_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    shift_sequencer_if.slave    bus,
    output logic                busy
);

    localparam logic [AMT_W-1:0] STEP_MAX_A = AMT_W'(STEP_MAX);

    state_t             state, state_d;
    logic [DATA_W-1:0]  acc, acc_d;
    logic [AMT_W-1:0]   rem, rem_d;
    logic               dir, dir_d;
    logic               ready_q, ready_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;

    logic [AMT_W-1:0]   step_c;
    logic [DATA_W-1:0]  shift_out;

    // Per-pass shift is the remaining amount clipped to the shifter range.
    always_comb begin
        step_c = (rem > STEP_MAX_A) ? STEP_MAX_A : rem;
    end

    barrel_shifter u_shift (
        .IN    (acc),
        .OUT   (shift_out),
        .dir   (dir),
        .shift (SHIFT_W'(step_c))
    );

    // Next-state and register-update logic.
    always_comb begin
        state_d = state;
        acc_d   = acc;
        rem_d   = rem;
        dir_d   = dir;
        case (state)
            ST_IDLE: begin
                if (bus.in_valid && ready_q) begin
                    acc_d   = bus.in_data;
                    dir_d   = bus.in_dir;
                    rem_d   = bus.in_amt;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                acc_d = shift_out;
                rem_d = rem - step_c;
                // Decision uses the pre-pass remainder: this is the last pass.
                if (rem <= STEP_MAX_A) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        ready_d = (state_d == ST_IDLE);
        valid_d = (state_d == ST_DONE);
        busy_d  = (state_d != ST_IDLE);
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            acc     <= '0;
            rem     <= '0;
            dir     <= DIR_LEFT;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state   <= state_d;
            acc     <= acc_d;
            rem     <= rem_d;
            dir     <= dir_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.in_ready  = ready_q;
    assign bus.out_valid = valid_q;
    assign bus.out_data  = acc;
    assign busy          = busy_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: transaction-level model plus
// directed commands with hand-computed results and latencies.
module tb_shift_sequencer;
    import shift_seq_pkg::*;

    localparam int unsigned AMT_W = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy;

    shift_sequencer_if #(.AMT_W(AMT_W)) bus ();

    shift_sequencer #(.AMT_W(AMT_W), .STEP_MAX(7)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // ---------------- transaction-level model ----------------
    bit         m_busy, m_ready, m_valid, m_known;
    int         m_left, m_p;
    logic [7:0] m_data, m_result;
    int         m_steps[$];

    function automatic int calc_passes(input int amt);
        return (amt == 0) ? 1 : (amt + 6) / 7;
    endfunction

    function automatic logic [7:0] calc_result(input logic [7:0] d, input logic dr, input int amt);
        logic [7:0] r;
        if (amt >= 8) r = 8'h00;
        else if (dr) r = d >> amt;
        else r = d << amt;
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy  = 1'b0;
            m_ready = 1'b0;
            m_valid = 1'b0;
            m_known = 1'b1;
            m_data  = 8'h00;
            m_left  = 0;
        end else begin
            if (!m_busy) begin
                if (bus.in_valid && m_ready) begin
                    int amt;
                    amt = int'(bus.in_amt);
                    m_p = calc_passes(amt);
                    m_steps.delete();
                    for (int i = 0; i < m_p; i++) begin
                        m_steps.push_back((amt - 7 * i > 7) ? 7 : amt - 7 * i);
                    end
                    m_result = calc_result(bus.in_data, bus.in_dir, amt);
                    m_left   = m_p;
                    m_busy   = 1'b1;
                    m_known  = 1'b0;
                end
            end else if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_valid = 1'b1;
                    m_data  = m_result;
                    m_known = 1'b1;
                end
            end else if (bus.out_ready) begin
                m_valid = 1'b0;
                m_busy  = 1'b0;
            end
            m_ready = !m_busy;
        end
    end

    // Every cycle out of reset: compare DUT against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            check("in_ready", 32'(bus.in_ready), 32'(m_ready));
            check("out_valid", 32'(bus.out_valid), 32'(m_valid));
            check("busy", 32'(busy), 32'(m_busy));
            if (m_known) check("out_data", 32'(bus.out_data), 32'(m_data));
            if (m_busy && m_left > 0)
                check("pass_shift", 32'(dut.u_shift.shift), 32'(m_steps[m_p - m_left]));
        end
    end

    // ---------------- directed stimulus ----------------
    logic [7:0] outs[$];

    task automatic send(input logic [7:0] d, input logic dr, input int amt);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_dir   = dr;
        bus.in_amt   = AMT_W'(amt);
        check("accept_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge after the result handshake.
    task automatic run_cmd(input string name, input logic [7:0] d, input logic dr,
                           input int amt, input logic [7:0] exp, input int exp_lat);
        int lat;
        outs.delete();
        send(d, dr, amt);
        lat = 1;
        while (!bus.out_valid && lat < 20) begin
            outs.push_back(dut.u_shift.OUT);
            @(negedge clk);
            lat++;
        end
        check({name, "_lat"}, 32'(lat), 32'(exp_lat));
        check({name, "_data"}, 32'(bus.out_data), 32'(exp));
        @(negedge clk);
        check({name, "_ready_back"}, 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        int n;
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.in_dir    = DIR_LEFT;
        bus.in_amt    = '0;
        bus.out_ready = 1'b1;

        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_data", 32'(bus.out_data), 32'h00);
        check("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_cmd("b3_l3",  8'hB3, DIR_LEFT,  3,  8'h98, 2);
        run_cmd("b3_r3",  8'hB3, DIR_RIGHT, 3,  8'h16, 2);
        run_cmd("b3_a0",  8'hB3, DIR_LEFT,  0,  8'hB3, 2);
        run_cmd("80_r15", 8'h80, DIR_RIGHT, 15, 8'h00, 4);
        check("80_r15_npass", 32'(outs.size()), 32'd3);
        if (outs.size() == 3) begin
            check("80_r15_pass0", 32'(outs[0]), 32'h01);
            check("80_r15_pass1", 32'(outs[1]), 32'h00);
            check("80_r15_pass2", 32'(outs[2]), 32'h00);
        end
        run_cmd("01_l7",  8'h01, DIR_LEFT,  7,  8'h80, 2);
        run_cmd("01_l31", 8'h01, DIR_LEFT,  31, 8'h00, 6);
        run_cmd("ff_r7",  8'hFF, DIR_RIGHT, 7,  8'h01, 2);
        run_cmd("ff_l8",  8'hFF, DIR_LEFT,  8,  8'h00, 3);
        run_cmd("ff_r14", 8'hFF, DIR_RIGHT, 14, 8'h00, 3);

        // Backpressure in DONE with a competing command held on the input.
        bus.out_ready = 1'b0;
        send(8'h5A, DIR_LEFT, 1);
        n = 0;
        while (!bus.out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("bp_valid_seen", 32'(bus.out_valid), 32'd1);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h01;
        bus.in_dir   = DIR_LEFT;
        bus.in_amt   = AMT_W'(7);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_hold_valid", 32'(bus.out_valid), 32'd1);
            check("bp_hold_data", 32'(bus.out_data), 32'hB4);
            check("bp_hold_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("bp_next_data", 32'(bus.out_data), 32'h80);
        check("bp_next_valid", 32'(bus.out_valid), 32'd1);
        @(negedge clk);

        // Reset during the second pass of an amt-15 command.
        send(8'h80, DIR_RIGHT, 15);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("mid_rst_out_data", 32'(bus.out_data), 32'h00);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("post_rst_no_valid", 32'(bus.out_valid), 32'd0);
        end
        run_cmd("post_rst_b3_l3", 8'hB3, DIR_LEFT, 3, 8'h98, 2);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

Multi-pass shift controller that sits directly upstream of `barrel_shifter` and also consumes its result. It accepts shift commands whose amount exceeds the shifter's 3-bit range, splits each command into passes of at most 7 positions, and recirculates the shifter output through a local accumulator. A valid/ready handshake on each side lets a producer and consumer stall it. Data is 8 bits, matching `barrel_shifter`.

## Interface
- `AMT_W`, default 5: width of the requested shift amount (0..31).
- `STEP_MAX`, default 7: largest per-pass shift; must be ≤ 7.
- `clk` input, 1: single clock, rising edge.
- `rst_n` input, 1: reset, asynchronous and active-low.
- `in_valid` input, 1: command present.
- `in_ready` output, 1: command accepted when `in_valid && in_ready`.
- `in_data` input, 8: operand.
- `in_dir` input, 1: 0 = left shift, 1 = right shift.
- `in_amt` input, AMT_W: total shift amount.
- `out_valid` output, 1: result present.
- `out_ready` input, 1: consumer takes the result when `out_valid && out_ready`.
- `out_data` output, 8: shifted result.
- `busy` output, 1: high in RUN and DONE.

## Operation
- `barrel_shifter` semantics are logical shifts with zero fill; no rotation.
- States: IDLE, RUN, DONE.
- **IDLE:**
  - `in_ready` = 1.
  - On accept, latch `acc` = `in_data`, `dir` = `in_dir`, `rem` = `in_amt`, then go to RUN.
- **RUN, one pass per cycle:**
  - `step` = min(`rem`, STEP_MAX).
  - Shifter is driven with IN = `acc`, dir = `dir`, shift = `step`.
  - Update `acc` ← OUT and `rem` ← `rem` − `step`.
  - If `rem` ≤ STEP_MAX, go to DONE after this pass.
- **DONE:**
  - `out_valid` = 1 and `out_data` = `acc`.
  - On `out_ready`, return to IDLE.
  - `out_data` and `out_valid` stay stable while `out_ready` is low.
- Pass count P = max(1, ceil(`in_amt` / STEP_MAX)).
  - Amount 0 still performs one pass with shift 0; the result equals the operand.
- Amount ≥ 8 gives 0x00; all passes still run, with no early exit.
- `in_ready` is low in RUN and DONE. Commands are not queued, and there is no accept in the same cycle as a DONE handshake.
- `rem` arithmetic is unsigned AMT_W bits. `rem` never underflows because `step` ≤ `rem`.

## Timing
- Command accepted at edge T:
  - RUN occupies cycles T+1 .. T+P.
  - `out_valid` rises after edge T+P, i.e. in the cycle following the final pass.
  - Minimum latency from accept to `out_valid` is 2 cycles; maximum is 6 cycles (amount 31, 5 passes).
- Result handshake at edge U: state is IDLE and `in_ready` = 1 after U.
- Reset values: `in_ready` = 0 while `rst_n` is low, then 1 (IDLE); `out_valid` = 0, `out_data` = 0x00, `busy` = 0; `acc`, `rem` and `dir` = 0.
- Reset asserted mid-RUN or mid-DONE:
  - Immediately returns to IDLE and clears `out_valid`.
  - The in-flight command is dropped and no partial result is presented.
- `out_data` is registered (from `acc`). The shifter path is combinational within one cycle.

## Structure
- Package `shift_seq_pkg`:
  - State enum (IDLE, RUN, DONE).
  - `DIR_LEFT` = 0 and `DIR_RIGHT` = 1.
  - `STEP_MAX_DEFAULT` = 7 and data width constant 8.
- One sub-module instance: the existing `barrel_shifter` (ports IN, OUT, dir, shift), instance name `u_shift`.
- The FSM, accumulator and remaining-count registers live in `shift_sequencer`. No further hierarchy.

## Test plan
- `in_data` = 0xB3, left, amt 3, `out_ready` held high → `out_data` = 0x98 with `out_valid` 2 cycles after accept; `in_ready` returns the next cycle.
- 0xB3, right, amt 3 → 0x16 after 1 pass. 0xB3, amt 0 → 0xB3 after 1 pass with shift 0.
- 0x80, right, amt 15 → passes of 7, 7, 1 (0x01, 0x00, 0x00); `out_valid` at accept+4; bench monitors the per-pass shift values.
- 0x01, left, amt 7 → 0x80 in one pass. 0x01, left, amt 31 → 0x00 after 5 passes; `out_valid` at accept+6.
- Backpressure: hold `out_ready` low 5 cycles in DONE → `out_data` and `out_valid` stable, `in_ready` low, new `in_valid` ignored; result taken on release, next command then accepted.
- Drop `rst_n` low during the second pass of an amt-15 command → outputs cleared asynchronously, no `out_valid` after release, and a fresh 0xB3 left-3 command yields 0x98.
